// File: rtl/tmrx_err_pkg.sv
// ============================================================================
// Module      : tmrx_err_pkg
// Description : Shared types and default constants for the TMR voter error
//               collector (FSM state encoding and snapshot record layout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmrx_err_pkg;

  // Default configuration of the collector
  localparam int unsigned C_N_SRC = 4;
  localparam int unsigned C_CNT_W = 8;
  localparam int unsigned C_TS_W  = 16;

  // Collector FSM state, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SEND = 2'd2
  } err_state_e;

  // Snapshot record in the default configuration
  typedef struct packed {
    logic [C_N_SRC-1:0] src;
    logic [C_CNT_W-1:0] cnt;
    logic [C_TS_W-1:0]  tstamp;
  } err_rec_t;

endpackage

`default_nettype wire

// File: rtl/tmrx_sat_cnt.sv
// ============================================================================
// Module      : tmrx_sat_cnt
// Description : Width-parameterised saturating incrementer with synchronous
//               clear. nxt_o shows the value the count takes after this cycle
//               if it is not cleared, so a consumer can snapshot the count
//               including the current increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmrx_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] nxt_o
);

  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;

  // Increment unless already at the maximum; never wraps
  always_comb begin
    w_nxt = r_cnt;
    if (inc_i && (r_cnt != C_MAX)) begin
      w_nxt = r_cnt + W'(1);
    end
  end

  // Count register; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign nxt_o = w_nxt;

endmodule

`default_nettype wire

// File: rtl/tmrx_err_collector.sv
// ============================================================================
// Module      : tmrx_err_collector
// Description : Collects TMR voter mismatch flags into sticky per-source bits
//               and a saturating error-cycle count, and presents them to a
//               host as snapshot records on a valid/ready port. irq_o stays
//               high while any error is unreported.
//               Optional feature macro TMRX_ERR_TSTAMP_EN adds a free-running
//               cycle stamp of the first error in each window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmrx_err_collector
  import tmrx_err_pkg::*;
#(
  parameter int unsigned N_SRC = C_N_SRC,
  parameter int unsigned CNT_W = C_CNT_W,
  parameter int unsigned TS_W  = C_TS_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] err_i,
  input  logic             clr_i,
  output logic             irq_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [N_SRC-1:0] rd_src_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [TS_W-1:0]  rd_tstamp_o
);

  err_state_e       r_state;
  logic [N_SRC-1:0] r_acc_src;
  logic             r_irq;
  logic             r_valid;
  logic [N_SRC-1:0] r_src;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic             w_hs;
  logic             w_pend;
  logic [CNT_W-1:0] w_acc_cnt_nxt;

  assign w_any  = |err_i;
  assign w_hs   = r_valid & rd_ready_i;
  assign w_pend = (r_state == PEND);

  // Error-cycle accumulator; emptied when the snapshot is taken or on flush
  tmrx_sat_cnt #(
    .W (CNT_W)
  ) u_acc_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i | w_pend),
    .inc_i  (w_any),
    .nxt_o  (w_acc_cnt_nxt)
  );

  // Collector FSM with sticky source accumulator and registered record port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_acc_src <= '0;
      r_irq     <= 1'b0;
      r_valid   <= 1'b0;
      r_src     <= '0;
      r_cnt     <= '0;
    end else if (clr_i) begin
      r_state   <= IDLE;
      r_acc_src <= '0;
      r_irq     <= 1'b0;
      r_valid   <= 1'b0;
      r_src     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_acc_src <= r_acc_src | err_i;
          if (w_any) begin
            r_state <= PEND;
            r_irq   <= 1'b1;
          end
        end
        PEND: begin
          // This cycle's flags belong to the record being built
          r_acc_src <= '0;
          r_src     <= r_acc_src | err_i;
          r_cnt     <= w_acc_cnt_nxt;
          r_valid   <= 1'b1;
          r_irq     <= 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          // Flags seen while a record is presented go to the next window
          r_acc_src <= r_acc_src | err_i;
          if (w_hs) begin
            r_valid <= 1'b0;
            if ((r_acc_src != '0) || w_any) begin
              r_state <= PEND;
            end else begin
              r_state <= IDLE;
              r_irq   <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_acc_src <= '0;
          r_irq     <= 1'b0;
          r_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMRX_ERR_TSTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_acc_ts;
  logic [TS_W-1:0] r_ts;

  // Free-running cycle stamp, wraps modulo 2^TS_W and ignores flushes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end
  end

  // Stamp of the first error of the window, moved to the record at snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_ts <= '0;
      r_ts     <= '0;
    end else if (clr_i) begin
      r_acc_ts <= '0;
      r_ts     <= '0;
    end else if (w_pend) begin
      r_ts     <= r_acc_ts;
      r_acc_ts <= '0;
    end else if ((r_acc_src == '0) && w_any) begin
      r_acc_ts <= r_ts_cnt;
    end
  end

  assign rd_tstamp_o = r_ts;
`else
  assign rd_tstamp_o = '0;
`endif

  assign irq_o      = r_irq;
  assign rd_valid_o = r_valid;
  assign rd_src_o   = r_src;
  assign rd_cnt_o   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tmrx_err_collector.sv
// ============================================================================
// Module      : tb_tmrx_err_collector
// Description : Scoreboard bench for tmrx_err_collector. Stimulus pushes the
//               hand-computed records; a monitor pops and compares them at
//               each handshake. Timing and flush behaviour are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmrx_err_collector;
  import tmrx_err_pkg::*;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SRC-1:0] err;
  logic             clr;
  logic             irq;
  logic             rd_valid;
  logic             rd_ready;
  logic [N_SRC-1:0] rd_src;
  logic [CNT_W-1:0] rd_cnt;
  logic [TS_W-1:0]  rd_tstamp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  err_rec_t exp_q[$];

  tmrx_err_collector #(
    .N_SRC (N_SRC),
    .CNT_W (CNT_W),
    .TS_W  (TS_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .err_i       (err),
    .clr_i       (clr),
    .irq_o       (irq),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_src_o    (rd_src),
    .rd_cnt_o    (rd_cnt),
    .rd_tstamp_o (rd_tstamp)
  );

  always #5 clk = ~clk;

  // Bench copy of the cycle stamp: edges since reset release
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_ts(input int t);
`ifdef TMRX_ERR_TSTAMP_EN
    return 16'(t);
`else
    return 16'(0 * t);
`endif
  endfunction

  task automatic push(input logic [3:0] s, input int c, input int t);
    err_rec_t r;
    r.src    = s;
    r.cnt    = 8'(c);
    r.tstamp = exp_ts(t);
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: each accepted record must match the oldest expected one
  initial begin
    err_rec_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", {28'd0, rd_src}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rec_src", {28'd0, rd_src}, {28'd0, e.src});
          check("rec_cnt", {28'd0, rd_cnt}, {24'd0, e.cnt});
          check("rec_tstamp", {16'd0, rd_tstamp}, {16'd0, e.tstamp});
        end
      end
    end
  end

  // Watchdog: never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    int n;
    rst_n    = 1'b0;
    err      = '0;
    clr      = 1'b0;
    rd_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state held with no errors
    for (int i = 0; i < 20; i++) begin
      check("reset_idle", {9'd0, irq, rd_valid, rd_src, rd_cnt, rd_tstamp}, 32'd0);
      step();
    end

    // Single error in cycle 100, ready high
    n = 0;
    while (cyc != 100 && n < 200) begin
      step();
      n++;
    end
    check("reach_cycle_100", 32'(cyc), 32'd100);
    err = 4'b0010;
    rd_ready = 1'b1;
    push(4'b0010, 1, cyc);
    step();
    err = '0;
    check("single_irq_rise", {31'd0, irq}, 32'd1);
    check("single_valid_low", {31'd0, rd_valid}, 32'd0);
    step();
    check("single_valid_rise", {31'd0, rd_valid}, 32'd1);
    step();
    check("single_idle", {30'd0, irq, rd_valid}, 32'd0);
    check("single_drain", 32'(exp_q.size()), 32'd0);

    // Saturation: 20 error cycles with ready low
    rd_ready = 1'b0;
    t0 = cyc;
    push(4'b0001, 2, t0);
    push(4'b0001, 15, t0 + 2);
    err = 4'b0001;
    repeat (20) step();
    err = '0;
    step();
    check("sat_hold_valid", {30'd0, irq, rd_valid}, 32'd3);
    check("sat_hold_src", {28'd0, rd_src}, 32'd1);
    check("sat_hold_cnt", {28'd0, rd_cnt}, 32'd2);
    rd_ready = 1'b1;
    drain("sat", 20);
    check("sat_idle", {30'd0, irq, rd_valid}, 32'd0);

    // Errors during SEND stay out of the presented record
    rd_ready = 1'b0;
    t0 = cyc;
    err = 4'b0100;
    push(4'b0100, 1, t0);
    step();
    err = '0;
    step();
    t1 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        err = 4'b1000;
        t1 = cyc;
        push(4'b1000, 1, t1);
      end else begin
        err = '0;
      end
      check("send_hold_valid", {31'd0, rd_valid}, 32'd1);
      check("send_hold_rec", {24'd0, rd_src, rd_cnt}, {24'd0, 4'b0100, 4'd1});
      step();
    end
    err = '0;
    rd_ready = 1'b1;
    drain("send_hold", 20);
    check("send_hold_idle", {30'd0, irq, rd_valid}, 32'd0);

    // Handshake coinciding with an error feeds the next window
    t0 = cyc;
    push(4'b0001, 2, t0);
    push(4'b0001, 1, t0 + 2);
    err = 4'b0001;
    repeat (3) step();
    err = '0;
    drain("hs_err", 20);
    check("hs_err_idle", {30'd0, irq, rd_valid}, 32'd0);

    // Flush while a record is presented drops it
    rd_ready = 1'b0;
    err = 4'b0011;
    step();
    err = '0;
    step();
    check("clr_pre_valid", {31'd0, rd_valid}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_outputs", {9'd0, irq, rd_valid, rd_src, rd_cnt, rd_tstamp}, 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("clr_no_record", {30'd0, irq, rd_valid}, 32'd0);
      step();
    end

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
